// File: rtl/mult_if_pkg.sv
// Shared types and constants for the block-multiplier host (mult_host) and its operand buffer.
package mult_if_pkg;

    localparam int MULT_OP_W   = 16;
    localparam int MULT_PROD_W = 2 * MULT_OP_W;

    typedef enum logic [2:0] {
        IDLE,
        FEED,
        WAIT_FULL,
        REQ,
        DRAIN,
        ERR
    } mult_host_state_t;

    // Full-precision unsigned product of one operand pair, used by the result checker.
    function automatic logic [MULT_PROD_W-1:0] mult_product(input logic [MULT_OP_W-1:0] a,
                                                            input logic [MULT_OP_W-1:0] b);
        return MULT_PROD_W'(a) * MULT_PROD_W'(b);
    endfunction

endpackage

// File: rtl/mult_host_opbuf.sv
// Operand-pair history for the result checker: one pair per block slot, written in issue order,
// read combinationally at the readback index. Only instantiated when MULT_HOST_CHECK_EN is defined.
module mult_host_opbuf
    import mult_if_pkg::*;
#(
    parameter int LOGDEPTH = 6
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [LOGDEPTH-1:0]  wr_addr,
    input  logic [MULT_OP_W-1:0] wr_a,
    input  logic [MULT_OP_W-1:0] wr_b,
    input  logic [LOGDEPTH-1:0]  rd_addr,
    output logic [MULT_OP_W-1:0] rd_a,
    output logic [MULT_OP_W-1:0] rd_b
);

    localparam int DEPTH = 2 ** LOGDEPTH;

    logic [MULT_PROD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= {wr_a, wr_b};
        end
    end

    assign {rd_a, rd_b} = mem[rd_addr];

endmodule

// File: rtl/mult_host.sv
// Host side of the block multiplier: feeds one block of operand pairs, requests readback and tags the
// returned stream. Optional result checker is enabled by defining MULT_HOST_CHECK_EN.
module mult_host
    import mult_if_pkg::*;
#(
    parameter int LOGDEPTH = 6,
    parameter int WIDTH    = 32,
    parameter int TIMEOUT  = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [MULT_OP_W-1:0] op_a,
    input  logic [MULT_OP_W-1:0] op_b,
    output logic                 EN_mult,
    output logic [MULT_OP_W-1:0] mult_input0,
    output logic [MULT_OP_W-1:0] mult_input1,
    input  logic                 RDY_mult,
    output logic                 EN_blockRead,
    input  logic                 VALID_memVal,
    input  logic [WIDTH-1:0]     memVal_data,
    output logic                 res_valid,
    output logic [WIDTH-1:0]     res_data,
    output logic [LOGDEPTH-1:0]  res_index,
    output logic                 res_last,
    output logic                 busy,
    output logic                 err_timeout,
    output logic [15:0]          block_count,
    output logic [15:0]          mismatch_cnt
);

    localparam logic [LOGDEPTH-1:0] LAST_IDX   = {LOGDEPTH{1'b1}};
    localparam int                  WDOG_W     = $clog2(TIMEOUT + 1);
    localparam logic [WDOG_W-1:0]   WDOG_LIMIT = WDOG_W'(TIMEOUT - 1);

    mult_host_state_t state, next_state;

    logic [LOGDEPTH-1:0] wr_cnt;
    logic [LOGDEPTH-1:0] rd_cnt;
    logic [WDOG_W-1:0]   wdog;

    logic op_xfer;
    logic beat;
    logic watching;
    logic progress;
    logic wdog_expire;

    assign op_xfer     = (state == FEED) && op_valid && RDY_mult;
    assign beat        = ((state == REQ) || (state == DRAIN)) && VALID_memVal;
    assign watching    = (state == WAIT_FULL) || (state == REQ) || (state == DRAIN);
    assign progress    = ((state == WAIT_FULL) && !RDY_mult) || beat;
    assign wdog_expire = watching && !progress && (wdog == WDOG_LIMIT);

    // Block sequencing; a stuck multiplier in any waiting state overrides everything and parks in ERR.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:      if (op_valid) next_state = FEED;
            FEED:      if (op_xfer && (wr_cnt == LAST_IDX)) next_state = WAIT_FULL;
            WAIT_FULL: if (!RDY_mult) next_state = REQ;
            REQ:       if (beat) next_state = (rd_cnt == LAST_IDX) ? IDLE : DRAIN;
            DRAIN:     if (beat && (rd_cnt == LAST_IDX)) next_state = IDLE;
            ERR:       next_state = ERR;
            default:   next_state = IDLE;
        endcase
        if (wdog_expire) begin
            next_state = ERR;
        end
    end

    always_comb begin
        op_ready    = (state == FEED) && RDY_mult;
        EN_mult     = op_xfer;
        mult_input0 = (state == FEED) ? op_a : '0;
        mult_input1 = (state == FEED) ? op_b : '0;
        busy        = (state != IDLE);
        err_timeout = (state == ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            wr_cnt       <= '0;
            rd_cnt       <= '0;
            wdog         <= '0;
            EN_blockRead <= 1'b0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            res_index    <= '0;
            res_last     <= 1'b0;
            block_count  <= '0;
        end else begin
            state        <= next_state;
            EN_blockRead <= (next_state == REQ);
            res_valid    <= beat;
            res_last     <= beat && (rd_cnt == LAST_IDX);
            if (op_xfer) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
            if (beat) begin
                res_data  <= memVal_data;
                res_index <= rd_cnt;
                rd_cnt    <= rd_cnt + 1'b1;
                if (rd_cnt == LAST_IDX) begin
                    block_count <= block_count + 16'd1;
                end
            end
            // Any progress or state change restarts the idle window.
            if (!watching || progress || (next_state != state)) begin
                wdog <= '0;
            end else begin
                wdog <= wdog + 1'b1;
            end
        end
    end

`ifdef MULT_HOST_CHECK_EN
    logic [MULT_OP_W-1:0] chk_a;
    logic [MULT_OP_W-1:0] chk_b;
    logic [WIDTH-1:0]     chk_expected;

    mult_host_opbuf #(
        .LOGDEPTH (LOGDEPTH)
    ) u_opbuf (
        .clk     (clk),
        .wr_en   (op_xfer),
        .wr_addr (wr_cnt),
        .wr_a    (op_a),
        .wr_b    (op_b),
        .rd_addr (rd_cnt),
        .rd_a    (chk_a),
        .rd_b    (chk_b)
    );

    assign chk_expected = WIDTH'(mult_product(chk_a, chk_b));

    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_cnt <= '0;
        end else if (beat && (memVal_data != chk_expected) && (mismatch_cnt != 16'hFFFF)) begin
            mismatch_cnt <= mismatch_cnt + 16'd1;
        end
    end
`else
    assign mismatch_cnt = '0;
`endif

endmodule
